rdyval2reqack_tph: RTL and testbench

//   Transmit-side companion of the two-phase Req/Ack -> Ready/Valid converter.
//   - Accepts words on a Ready/Valid input.
//   - Issues each word as one toggle of a two-phase Req/Ack output; o_dat is held stable until acknowledged.
//   - Sits on the source side of a clock-domain boundary, or of any two-phase link.
//   - Optional one-entry holding buffer: the next word is taken while a request is still outstanding.
//

---
 rtl/rdyval2reqack_tph_pkg.sv | 12 +
 rtl/rdyval2reqack_tph_cdc_sync2.sv | 26 ++
 rtl/rdyval2reqack_tph.sv | 92 +++++++++
 tb/tb_rdyval2reqack_tph.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rdyval2reqack_tph_pkg.sv
// Shared constants and helpers for the two-phase Req/Ack transmit converter
// and its synchronizer.
package rdyval2reqack_tph_pkg;

    localparam int SYNC_STAGES = 2;

    // A request is outstanding whenever the two link phases disagree.
    function automatic logic req_pending(input logic req_phase, input logic ack_phase);
        return req_phase ^ ack_phase;
    endfunction

endpackage

// File: rtl/rdyval2reqack_tph_cdc_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to zero; shared with
// the receive-side converter.
module cdc_sync2
    import rdyval2reqack_tph_pkg::*;
#(
    parameter int DWIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] d,
    output logic [DWIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][DWIDTH-1:0] sync_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_chain[SYNC_STAGES-1];

endmodule

// File: rtl/rdyval2reqack_tph.sv
// Ready/Valid to two-phase Req/Ack converter (transmit side), with optional
// ack synchronizer and optional one-entry holding buffer.
module rdyval2reqack_tph
    import rdyval2reqack_tph_pkg::*;
#(
    parameter int DWIDTH      = 1,
    parameter bit INCLUDE_CDC = 1'b0,
    parameter bit INCLUDE_BUF = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld,
    output logic              rdy,
    input  logic [DWIDTH-1:0] i_dat,
    output logic              req,
    input  logic              ack,
    output logic [DWIDTH-1:0] o_dat
);

    logic              ack_i;
    logic              pend;
    logic              xfer;
    logic              launch;
    logic [DWIDTH-1:0] launch_dat;

    generate
        if (INCLUDE_CDC) begin : g_cdc
            cdc_sync2 #(
                .DWIDTH(1)
            ) u_ack_sync (
                .clk  (clk),
                .rst_n(rst_n),
                .d    (ack),
                .q    (ack_i)
            );
        end else begin : g_no_cdc
            assign ack_i = ack;
        end
    endgenerate

    assign pend = req_pending(req, ack_i);
    assign xfer = vld & rdy;

    generate
        if (INCLUDE_BUF) begin : g_buf
            logic              full;
            logic              full_nxt;
            logic [DWIDTH-1:0] buf_dat;

            // rdy depends only on the buffer flag, so nothing from ack reaches it.
            assign rdy        = ~full;
            assign launch     = ~pend & (full | xfer);
            assign launch_dat = full ? buf_dat : i_dat;
            assign full_nxt   = pend ? (full | xfer) : (full & xfer);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    full <= 1'b0;
                end else begin
                    full <= full_nxt;
                end
            end

            // A new word parks here whenever it cannot go straight to the output.
            always_ff @(posedge clk) begin
                if (xfer && (pend || full)) begin
                    buf_dat <= i_dat;
                end
            end
        end else begin : g_no_buf
            assign rdy        = ~pend;
            assign launch     = xfer;
            assign launch_dat = i_dat;
        end
    endgenerate

    // Launch stage: each launched word is one toggle of req with o_dat held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req <= 1'b0;
        end else if (launch) begin
            req <= ~req;
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            o_dat <= launch_dat;
        end
    end

endmodule

// File: tb/tb_rdyval2reqack_tph.sv
// Bench for rdyval2reqack_tph: directed scenarios on three configurations plus
// randomized traffic checked by per-lane scoreboards against a receiver model.
module tb_rdyval2reqack_tph;

    localparam int DW          = 8;
    localparam int NWORDS      = 1000;
    localparam int LANE_BUDGET = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          vld   [3];
    logic          rdy   [3];
    logic          req   [3];
    logic          ack   [3];
    logic [DW-1:0] i_dat [3];
    logic [DW-1:0] o_dat [3];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q [3][$];
    bit            mon_done [3];

    // Lane 0: plain, lane 1: holding buffer, lane 2: ack synchronizer.
    rdyval2reqack_tph #(.DWIDTH(DW), .INCLUDE_CDC(1'b0), .INCLUDE_BUF(1'b0)) u_plain (
        .clk(clk), .rst_n(rst_n), .vld(vld[0]), .rdy(rdy[0]), .i_dat(i_dat[0]),
        .req(req[0]), .ack(ack[0]), .o_dat(o_dat[0]));
    rdyval2reqack_tph #(.DWIDTH(DW), .INCLUDE_CDC(1'b0), .INCLUDE_BUF(1'b1)) u_buf (
        .clk(clk), .rst_n(rst_n), .vld(vld[1]), .rdy(rdy[1]), .i_dat(i_dat[1]),
        .req(req[1]), .ack(ack[1]), .o_dat(o_dat[1]));
    rdyval2reqack_tph #(.DWIDTH(DW), .INCLUDE_CDC(1'b1), .INCLUDE_BUF(1'b0)) u_cdc (
        .clk(clk), .rst_n(rst_n), .vld(vld[2]), .rdy(rdy[2]), .i_dat(i_dat[2]),
        .req(req[2]), .ack(ack[2]), .o_dat(o_dat[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source: offers random words, records each accepted word in order.
    task automatic drive_lane(input int k);
        int sent = 0;
        int cyc  = 0;
        bit took;
        while (sent < NWORDS && cyc < LANE_BUDGET) begin
            @(negedge clk);
            took = vld[k] && rdy[k];
            if (took) begin
                exp_q[k].push_back(i_dat[k]);
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (took || !vld[k]) begin
                if (sent < NWORDS && $urandom_range(0, 3) != 0) begin
                    vld[k]   = 1'b1;
                    i_dat[k] = DW'($urandom);
                end else begin
                    vld[k] = 1'b0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                vld[k] = 1'b0;
            end
        end
        vld[k] = 1'b0;
        check($sformatf("lane%0d_words_sent", k), sent, NWORDS);
    endtask

    // Monitor: every req toggle delivers the next expected word.
    task automatic monitor_lane(input int k);
        int            got = 0;
        int            cyc = 0;
        logic          prev_req;
        logic [DW-1:0] last;
        prev_req = req[k];
        last     = o_dat[k];
        while (got < NWORDS && cyc < LANE_BUDGET) begin
            @(negedge clk);
            cyc++;
            if (req[k] !== prev_req) begin
                check($sformatf("lane%0d_word_expected", k), exp_q[k].size() != 0, 1);
                if (exp_q[k].size() != 0)
                    check($sformatf("lane%0d_word%0d", k, got), o_dat[k], exp_q[k].pop_front());
                got++;
                prev_req = req[k];
                last     = o_dat[k];
            end else if (req[k] !== ack[k]) begin
                check($sformatf("lane%0d_odat_stable", k), o_dat[k], last);
            end
            if (k == 0)
                check("lane0_rdy_vs_pend", rdy[k], req[k] == ack[k]);
        end
        check($sformatf("lane%0d_words_seen", k), got, NWORDS);
        check($sformatf("lane%0d_queue_drained", k), exp_q[k].size(), 0);
        mon_done[k] = 1'b1;
    endtask

    // Receiver model: acknowledges each outstanding request after 0..4 cycles.
    task automatic ack_lane(input int k);
        int dly = $urandom_range(0, 4);
        while (!mon_done[k]) begin
            @(posedge clk);
            #1;
            if (req[k] !== ack[k]) begin
                if (dly == 0) begin
                    ack[k] = req[k];
                    dly    = $urandom_range(0, 4);
                end else begin
                    dly--;
                end
            end
        end
    endtask

    task automatic run_lane(input int k);
        fork
            drive_lane(k);
            monitor_lane(k);
            ack_lane(k);
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vld[k]      = 1'b0;
            ack[k]      = 1'b0;
            i_dat[k]    = '0;
            mon_done[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset release, no traffic: idle and ready.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("lane%0d_idle_req", k), req[k], 0);
                if (c == 0 || c == 19) check($sformatf("lane%0d_idle_rdy", k), rdy[k], 1);
            end
        end

        // Plain lane: one word, then combinational rdy from ack.
        @(posedge clk); #1;
        vld[0] = 1'b1; i_dat[0] = 8'hA5;
        @(posedge clk); #1;
        vld[0] = 1'b0; i_dat[0] = 8'h00;
        @(negedge clk);
        check("plain_req", req[0], 1);
        check("plain_odat", o_dat[0], 8'hA5);
        check("plain_rdy_pend", rdy[0], 0);
        repeat (2) @(posedge clk); #1;
        check("plain_rdy_wait", rdy[0], 0);
        ack[0] = 1'b1;
        #1;
        check("plain_rdy_comb", rdy[0], 1);

        // Buffered lane: two words taken with ack withheld, third refused.
        @(posedge clk); #1;
        vld[1] = 1'b1; i_dat[1] = 8'h01;
        @(posedge clk); #1;
        i_dat[1] = 8'h02;
        check("buf_first_req", req[1], 1);
        check("buf_first_odat", o_dat[1], 8'h01);
        check("buf_first_rdy", rdy[1], 1);
        @(posedge clk); #1;
        i_dat[1] = 8'h03;
        @(negedge clk);
        check("buf_full_rdy", rdy[1], 0);
        check("buf_full_req", req[1], 1);
        check("buf_full_odat", o_dat[1], 8'h01);
        @(posedge clk); #1;
        check("buf_third_refused", rdy[1], 0);
        ack[1] = 1'b1;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        @(negedge clk);
        check("buf_second_req", req[1], 0);
        check("buf_second_odat", o_dat[1], 8'h02);
        check("buf_second_rdy", rdy[1], 1);
        @(posedge clk); #1;
        ack[1] = 1'b0;

        // Synchronized lane: rdy follows ack exactly two cycles later.
        @(posedge clk); #1;
        vld[2] = 1'b1; i_dat[2] = 8'h3C;
        @(posedge clk); #1;
        vld[2] = 1'b0;
        check("cdc_req", req[2], 1);
        check("cdc_odat", o_dat[2], 8'h3C);
        check("cdc_rdy_pend", rdy[2], 0);
        ack[2] = 1'b1;
        @(negedge clk);
        check("cdc_rdy_after0", rdy[2], 0);
        @(posedge clk);
        @(negedge clk);
        check("cdc_rdy_after1", rdy[2], 0);
        @(posedge clk);
        @(negedge clk);
        check("cdc_rdy_after2", rdy[2], 1);

        // Randomized traffic on all three lanes at once.
        @(posedge clk); #1;
        fork
            run_lane(0);
            run_lane(1);
            run_lane(2);
        join

        // Reset with a word outstanding and the buffer occupied.
        for (int k = 0; k < 3; k++) ack[k] = req[k];
        repeat (4) @(posedge clk); #1;
        vld[1] = 1'b1; i_dat[1] = 8'h11;
        @(posedge clk); #1;
        i_dat[1] = 8'h22;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        @(negedge clk);
        check("rst_pre_full", rdy[1], 0);
        check("rst_pre_pend", req[1] ^ ack[1], 1);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) ack[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lane%0d_rst_req", k), req[k], 0);
            check($sformatf("lane%0d_rst_rdy", k), rdy[k], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("lane%0d_post_rst_req", k), req[k], 0);
                check($sformatf("lane%0d_post_rst_rdy", k), rdy[k], 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
